tlul_host_arb: RTL and testbench
================================

Name: tlul_host_arb

Overview:
Arbitrates N TileLink-UL hosts onto one shared TL-UL device port, such as the DRAM PHY/memory path in the SoC.
- A channel: round-robin grant with a grant lock, so a stalled request stays stable.
- D channel: responses go back to the issuing host, in order, using a FIFO of granted host indices.
- The block sits between the host-side bus masters and a single in-order TL-UL target.

Parameters:
- NumHosts, 2, number of requesting hosts; legal range 2..8.
- MaxOutstanding, 4, depth of the in-flight tracking FIFO; power of 2, at least 2.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- tl_h_i  in  NumHosts x tlul_pkg::tl_h2d_t  host requests.
- tl_h_o  out  NumHosts x tlul_pkg::tl_d2h_t  host responses.
- tl_d_o  out  tlul_pkg::tl_h2d_t  request to the shared device.
- tl_d_i  in  tlul_pkg::tl_d2h_t  response from the shared device.
- outstanding_o  out  $clog2(MaxOutstanding+1)  number of in-flight transactions.
- err_o  out  1  sticky: device d_valid seen while nothing was outstanding.

Behaviour:
- Reset values: tl_d_o.a_valid=0, tl_d_o.d_ready=0, all tl_h_o[i].a_ready=0, all tl_h_o[i].d_valid=0, outstanding_o=0, err_o=0, FIFO empty, lock=0, rr pointer=0.
- Arbitration, one cycle:
  - Candidates are hosts with a_valid=1.
  - Round-robin: the winner is the first candidate at or after the rr pointer, wrapping modulo NumHosts.
- Lock:
  - If the granted host has a_valid=1 and the device a_ready=0, then lock=1 and the grant is frozen until that request fires.
  - New candidates are ignored while locked.
- A-channel forwarding:
  - tl_d_o A fields = the granted host's A fields, with a_source passed through unmodified.
  - tl_d_o.a_valid = granted a_valid AND NOT fifo_full.
  - Granted host a_ready = device a_ready AND NOT fifo_full; every other host sees a_ready=0.
  - Zero added latency: the path is combinational.
- A fire (a_valid and a_ready on the device side):
  - Push the granted host index.
  - Clear lock.
  - rr pointer = (granted index + 1) mod NumHosts.
- FIFO full:
  - A stalls even if a D pop occurs in the same cycle; no bypass.
  - The stall does not change the grant or lock state except as above.
- D routing:
  - Head index h selects the destination: tl_h_o[h] D fields = tl_d_i D fields, and tl_h_o[h].d_valid = device d_valid.
  - tl_d_o.d_ready = tl_h_i[h].d_ready.
  - Every other host sees d_valid=0.
  - Non-selected hosts' tl_h_o D fields are also driven from tl_d_i; only d_valid is gated.
- D fire: pop the FIFO.
- Simultaneous A fire and D fire: push and pop in the same cycle; the count is unchanged.
- FIFO empty:
  - tl_d_o.d_ready=0 and no host sees d_valid.
  - If device d_valid=1 in this state, err_o is set and stays set until reset.
- outstanding_o is registered and equals the FIFO occupancy.
- Reset mid-transaction: all state clears immediately. The bench resets the device side together with the arbiter.

Optional Feature:
- Macro TLUL_HOST_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, the lowest-index candidate wins; the rr pointer is not built; lock behaviour is unchanged.
- Undefined: round-robin as described.

Decomposition:
- top_pkg holds:
  - the constant TlArbMaxHosts=8;
  - typedef tl_host_idx_t = logic[$clog2(TlArbMaxHosts)-1:0].
- One sub-module, tlul_host_arb_fifo: synchronous FIFO of tl_host_idx_t with depth MaxOutstanding, full/empty flags and a count output, asynchronous active-low reset.

Test Plan:
- Host0 and host1 assert a_valid every cycle, device a_ready=1, responses immediate → grants alternate 0,1,0,1 with a fire every cycle; each d_valid goes to the correct host.
- Host1 alone requests while device a_ready=0 for 3 cycles, and host0 raises a_valid in cycle 2 → grant stays on host1 until it fires; host0 is granted the following cycle.
- MaxOutstanding=4, device never sends d_valid, 5 back-to-back requests → 4 fire; outstanding_o=4; 5th a_ready=0 until the first D fire.
- Issue order host1, host0, host1, then 3 responses → d_valid delivered to host1, host0, host1 in order; a host d_ready=0 stalls the device d_ready.
- Device d_valid=1 with the FIFO empty → err_o=1 the next cycle and held; after rst_ni pulsed low, err_o=0 and outstanding_o=0.
- Built with TLUL_HOST_ARB_FIXED_PRIO_EN and both hosts requesting continuously → host0 wins every cycle; host1 is granted only once host0 drops a_valid.

Source files
------------

// File: rtl/tlul_pkg.sv
// Minimal TileLink-UL channel structs shared by the host arbiter and its neighbours.
package tlul_pkg;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/top_pkg.sv
// Host-index type and helpers for the TL-UL host arbiter.
package top_pkg;

    localparam int TlArbMaxHosts = 8;

    typedef logic [$clog2(TlArbMaxHosts)-1:0] tl_host_idx_t;

    // Increment a host index, wrapping at the configured host count.
    function automatic tl_host_idx_t host_idx_inc(tl_host_idx_t idx, int num_hosts);
        tl_host_idx_t nxt;
        if (int'(idx) >= num_hosts - 1) nxt = '0;
        else                            nxt = idx + 1'b1;
        return nxt;
    endfunction

endpackage

// File: rtl/tlul_host_arb_fifo.sv
// In-flight tracking FIFO of granted host indices; head selects the D-channel destination.
module tlul_host_arb_fifo
    import top_pkg::*;
#(
    parameter int Depth = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  tl_host_idx_t                 wdata_i,
    input  logic                         pop_i,
    output tl_host_idx_t                 rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(Depth+1)-1:0]   count_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = $clog2(Depth + 1);

    tl_host_idx_t    mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] cnt_q;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/tlul_host_arb.sv
// N-to-1 TL-UL host arbiter: locked round-robin A grant, in-order D return via index FIFO.
// Define TLUL_HOST_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module tlul_host_arb
    import top_pkg::*;
#(
    parameter int NumHosts       = 2,
    parameter int MaxOutstanding = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  tlul_pkg::tl_h2d_t                   tl_h_i [NumHosts],
    output tlul_pkg::tl_d2h_t                   tl_h_o [NumHosts],
    output tlul_pkg::tl_h2d_t                   tl_d_o,
    input  tlul_pkg::tl_d2h_t                   tl_d_i,
    output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
    output logic                                err_o
);

    logic [NumHosts-1:0] req;
    tl_host_idx_t        arb_idx;
    logic                arb_found;
    tl_host_idx_t        gnt;
    logic                gnt_valid;
    tl_host_idx_t        gnt_q;
    logic                lock_q;
    logic                gnt_req;
    tlul_pkg::tl_h2d_t   gnt_h2d;
    tl_host_idx_t        head;
    logic                head_d_ready;
    logic                fifo_full;
    logic                fifo_empty;
    logic                dev_a_valid;
    logic                a_fire;
    logic                d_fire;
    logic                err_q;

    always_comb begin
        for (int i = 0; i < NumHosts; i++) req[i] = tl_h_i[i].a_valid;
    end

`ifdef TLUL_HOST_ARB_FIXED_PRIO_EN
    always_comb begin
        arb_idx   = '0;
        arb_found = 1'b0;
        for (int i = NumHosts - 1; i >= 0; i--) begin
            if (req[i]) begin
                arb_idx   = tl_host_idx_t'(i);
                arb_found = 1'b1;
            end
        end
    end
`else
    tl_host_idx_t rr_q;

    // First pass covers indices at or above the pointer, second pass wraps around.
    always_comb begin
        arb_idx   = '0;
        arb_found = 1'b0;
        for (int i = 0; i < NumHosts; i++) begin
            if (!arb_found && req[i] && (tl_host_idx_t'(i) >= rr_q)) begin
                arb_idx   = tl_host_idx_t'(i);
                arb_found = 1'b1;
            end
        end
        for (int i = 0; i < NumHosts; i++) begin
            if (!arb_found && req[i]) begin
                arb_idx   = tl_host_idx_t'(i);
                arb_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)     rr_q <= '0;
        else if (a_fire) rr_q <= host_idx_inc(gnt, NumHosts);
    end
`endif

    assign gnt = lock_q ? gnt_q : arb_idx;

    always_comb begin
        gnt_req      = 1'b0;
        gnt_h2d      = '0;
        head_d_ready = 1'b0;
        for (int i = 0; i < NumHosts; i++) begin
            if (gnt == tl_host_idx_t'(i)) begin
                gnt_req = req[i];
                gnt_h2d = tl_h_i[i];
            end
            if (head == tl_host_idx_t'(i)) head_d_ready = tl_h_i[i].d_ready;
        end
    end

    assign gnt_valid   = lock_q ? gnt_req : arb_found;
    assign dev_a_valid = gnt_valid & ~fifo_full;
    assign a_fire      = dev_a_valid & tl_d_i.a_ready;
    assign d_fire      = tl_d_i.d_valid & ~fifo_empty & head_d_ready;

    always_comb begin
        tl_d_o         = gnt_h2d;
        tl_d_o.a_valid = dev_a_valid;
        tl_d_o.d_ready = head_d_ready & ~fifo_empty;
    end

    // D payload fans out to every host; only valid and a_ready are per-host.
    always_comb begin
        for (int i = 0; i < NumHosts; i++) begin
            tl_h_o[i]         = tl_d_i;
            tl_h_o[i].a_ready = gnt_valid & (gnt == tl_host_idx_t'(i)) &
                                tl_d_i.a_ready & ~fifo_full;
            tl_h_o[i].d_valid = tl_d_i.d_valid & ~fifo_empty & (head == tl_host_idx_t'(i));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q <= 1'b0;
            gnt_q  <= '0;
        end else if (a_fire) begin
            lock_q <= 1'b0;
        end else if (gnt_valid && !tl_d_i.a_ready) begin
            lock_q <= 1'b1;
            gnt_q  <= gnt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                              err_q <= 1'b0;
        else if (tl_d_i.d_valid && fifo_empty)    err_q <= 1'b1;
    end

    assign err_o = err_q;

    tlul_host_arb_fifo #(
        .Depth (MaxOutstanding)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (a_fire),
        .wdata_i (gnt),
        .pop_i   (d_fire),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstanding_o)
    );

endmodule

// File: tb/tb_tlul_host_arb.sv
// Directed table-driven bench for tlul_host_arb (2 hosts, 4 outstanding).
module tb_tlul_host_arb;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    tlul_pkg::tl_h2d_t h_in  [2];
    tlul_pkg::tl_d2h_t h_out [2];
    tlul_pkg::tl_h2d_t dev_req;
    tlul_pkg::tl_d2h_t dev_rsp;
    logic [2:0]        outstanding;
    logic              err;

    int passed = 0;
    int total  = 0;

    tlul_host_arb #(
        .NumHosts       (2),
        .MaxOutstanding (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .tl_h_i        (h_in),
        .tl_h_o        (h_out),
        .tl_d_o        (dev_req),
        .tl_d_i        (dev_rsp),
        .outstanding_o (outstanding),
        .err_o         (err)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit av0, av1, ar, dv, dr0, dr1;
        bit e_av;
        int e_gnt;
        bit e_ar0, e_ar1, e_dv0, e_dv1, e_dr;
        int e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit av0, bit av1, bit ar, bit dv, bit dr0, bit dr1,
                                bit e_av, int e_gnt, bit e_ar0, bit e_ar1,
                                bit e_dv0, bit e_dv1, bit e_dr, int e_cnt);
        vec_t v;
        v.av0 = av0; v.av1 = av1; v.ar = ar; v.dv = dv; v.dr0 = dr0; v.dr1 = dr1;
        v.e_av = e_av; v.e_gnt = e_gnt; v.e_ar0 = e_ar0; v.e_ar1 = e_ar1;
        v.e_dv0 = e_dv0; v.e_dv1 = e_dv1; v.e_dr = e_dr; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(bit av0, bit av1, bit ar, bit dv, bit dr0, bit dr1);
        h_in[0].a_valid = av0;
        h_in[1].a_valid = av1;
        h_in[0].d_ready = dr0;
        h_in[1].d_ready = dr1;
        dev_rsp.a_ready = ar;
        dev_rsp.d_valid = dv;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        h_in[0] = '0;
        h_in[1] = '0;
        h_in[0].a_source  = 8'h10;
        h_in[1].a_source  = 8'h11;
        h_in[0].a_address = 32'h0000_1000;
        h_in[1].a_address = 32'h0000_2000;
        dev_rsp = '0;
        dev_rsp.d_data = 32'hCAFE_0001;
        rst_ni = 1'b0;
        #1;
        chk("rst a_valid", 32'(dev_req.a_valid), 0);
        chk("rst d_ready", 32'(dev_req.d_ready), 0);
        chk("rst a_ready0", 32'(h_out[0].a_ready), 0);
        chk("rst a_ready1", 32'(h_out[1].a_ready), 0);
        chk("rst d_valid0", 32'(h_out[0].d_valid), 0);
        chk("rst outstanding", 32'(outstanding), 0);
        chk("rst err", 32'(err), 0);
        repeat (2) tick();
        rst_ni = 1'b1;
        #1;

`ifdef TLUL_HOST_ARB_FIXED_PRIO_EN
        vecs.push_back(mk(1,1,1,0,1,1, 1,0,1,0,0,0,0,1));
        vecs.push_back(mk(1,1,1,1,1,1, 1,0,1,0,1,0,1,1));
        vecs.push_back(mk(1,1,1,1,1,1, 1,0,1,0,1,0,1,1));
        vecs.push_back(mk(1,1,1,1,1,1, 1,0,1,0,1,0,1,1));
        vecs.push_back(mk(0,1,1,1,1,1, 1,1,0,1,1,0,1,1));
        vecs.push_back(mk(0,0,1,1,1,1, 0,0,0,0,0,1,1,0));
        vecs.push_back(mk(0,1,0,0,1,1, 1,1,0,0,0,0,0,0));
        vecs.push_back(mk(1,1,0,0,1,1, 1,1,0,0,0,0,0,0));
        vecs.push_back(mk(1,1,1,0,1,1, 1,1,0,1,0,0,0,1));
        vecs.push_back(mk(1,1,1,1,1,1, 1,0,1,0,0,1,1,1));
        vecs.push_back(mk(0,0,1,1,1,1, 0,0,0,0,1,0,1,0));
`else
        // Alternating grants with immediate responses.
        vecs.push_back(mk(1,1,1,0,1,1, 1,0,1,0,0,0,0,1));
        vecs.push_back(mk(1,1,1,1,1,1, 1,1,0,1,1,0,1,1));
        vecs.push_back(mk(1,1,1,1,1,1, 1,0,1,0,0,1,1,1));
        vecs.push_back(mk(1,1,1,1,1,1, 1,1,0,1,1,0,1,1));
        vecs.push_back(mk(0,0,1,1,1,1, 0,0,0,0,0,1,1,0));
        // Host1 stalled and locked while host0 joins.
        vecs.push_back(mk(0,1,0,0,1,1, 1,1,0,0,0,0,0,0));
        vecs.push_back(mk(1,1,0,0,1,1, 1,1,0,0,0,0,0,0));
        vecs.push_back(mk(1,1,0,0,1,1, 1,1,0,0,0,0,0,0));
        vecs.push_back(mk(1,1,1,0,1,1, 1,1,0,1,0,0,0,1));
        vecs.push_back(mk(1,0,1,0,1,1, 1,0,1,0,0,0,1,2));
        vecs.push_back(mk(0,0,1,1,1,0, 0,0,0,0,0,1,0,2));
        vecs.push_back(mk(0,0,1,1,1,1, 0,0,0,0,0,1,1,1));
        vecs.push_back(mk(0,0,1,1,1,1, 0,0,0,0,1,0,1,0));
        // Issue host1, host0, host1 then return responses in order.
        vecs.push_back(mk(1,1,1,0,1,1, 1,1,0,1,0,0,0,1));
        vecs.push_back(mk(1,0,1,0,1,1, 1,0,1,0,0,0,1,2));
        vecs.push_back(mk(0,1,1,0,1,1, 1,1,0,1,0,0,1,3));
        vecs.push_back(mk(0,0,1,1,1,1, 0,0,0,0,0,1,1,2));
        vecs.push_back(mk(0,0,1,1,0,1, 0,0,0,0,1,0,0,2));
        vecs.push_back(mk(0,0,1,1,1,1, 0,0,0,0,1,0,1,1));
        vecs.push_back(mk(0,0,1,1,1,1, 0,0,0,0,0,1,1,0));
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].av0, vecs[i].av1, vecs[i].ar, vecs[i].dv, vecs[i].dr0, vecs[i].dr1);
            #1;
            chk($sformatf("v%0d dev a_valid", i), 32'(dev_req.a_valid), 32'(vecs[i].e_av));
            if (vecs[i].e_av)
                chk($sformatf("v%0d grant source", i), 32'(dev_req.a_source), 32'(8'h10 + vecs[i].e_gnt));
            chk($sformatf("v%0d a_ready0", i), 32'(h_out[0].a_ready), 32'(vecs[i].e_ar0));
            chk($sformatf("v%0d a_ready1", i), 32'(h_out[1].a_ready), 32'(vecs[i].e_ar1));
            chk($sformatf("v%0d d_valid0", i), 32'(h_out[0].d_valid), 32'(vecs[i].e_dv0));
            chk($sformatf("v%0d d_valid1", i), 32'(h_out[1].d_valid), 32'(vecs[i].e_dv1));
            chk($sformatf("v%0d dev d_ready", i), 32'(dev_req.d_ready), 32'(vecs[i].e_dr));
            tick();
            chk($sformatf("v%0d outstanding", i), 32'(outstanding), 32'(vecs[i].e_cnt));
        end
        chk("no err after table", 32'(err), 0);

        // FIFO full: four requests fire, the fifth waits for a D fire.
        drive(1, 0, 1, 0, 1, 1);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("fill%0d a_ready0", k), 32'(h_out[0].a_ready), 1);
            tick();
            chk($sformatf("fill%0d outstanding", k), 32'(outstanding), 32'(k + 1));
        end
        #1;
        chk("full dev a_valid", 32'(dev_req.a_valid), 0);
        chk("full a_ready0", 32'(h_out[0].a_ready), 0);
        tick();
        chk("full held outstanding", 32'(outstanding), 4);
        drive(1, 0, 1, 1, 1, 1);
        #1;
        chk("full pop a_ready0", 32'(h_out[0].a_ready), 0);
        chk("full pop d_valid0", 32'(h_out[0].d_valid), 1);
        chk("full pop d_ready", 32'(dev_req.d_ready), 1);
        chk("d_data fanout host1", h_out[1].d_data, 32'hCAFE_0001);
        tick();
        chk("after pop outstanding", 32'(outstanding), 3);
        drive(1, 0, 1, 0, 1, 1);
        #1;
        chk("refill a_ready0", 32'(h_out[0].a_ready), 1);
        tick();
        chk("refill outstanding", 32'(outstanding), 4);
        drive(0, 0, 1, 1, 1, 1);
        for (int k = 3; k >= 0; k--) begin
            tick();
            chk($sformatf("drain outstanding %0d", k), 32'(outstanding), 32'(k));
        end

        // Spurious response with nothing outstanding.
        #1;
        chk("spurious d_ready", 32'(dev_req.d_ready), 0);
        chk("spurious d_valid0", 32'(h_out[0].d_valid), 0);
        chk("spurious d_valid1", 32'(h_out[1].d_valid), 0);
        chk("err before edge", 32'(err), 0);
        tick();
        chk("err set", 32'(err), 1);
        drive(1, 0, 1, 0, 1, 1);
        tick();
        chk("err sticky", 32'(err), 1);
        chk("outstanding before reset", 32'(outstanding), 1);
        drive(0, 0, 0, 0, 1, 1);
        rst_ni = 1'b0;
        #1;
        chk("reset err", 32'(err), 0);
        chk("reset outstanding", 32'(outstanding), 0);
        chk("reset dev a_valid", 32'(dev_req.a_valid), 0);
        tick();
        rst_ni = 1'b1;
        tick();
        chk("post reset err", 32'(err), 0);
        chk("post reset outstanding", 32'(outstanding), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
